// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM port between CPUS cache channels.
// Each channel can raise a data read, data write or instruction read; a
// round-robin pointer picks the next channel while idle, and the granted
// transfer is held until the RAM reports ACCESS or the owner withdraws it.
module ram_arbiter #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32,
  localparam int OW    = (CPUS > 1) ? $clog2(CPUS) : 1
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [CPUS-1:0]          iREN,
  input  logic [CPUS-1:0]          dREN,
  input  logic [CPUS-1:0]          dWEN,
  input  logic [CPUS*WORD_W-1:0]   iaddr,
  input  logic [CPUS*WORD_W-1:0]   daddr,
  input  logic [CPUS*WORD_W-1:0]   dstore,
  output logic [CPUS-1:0]          iwait,
  output logic [CPUS-1:0]          dwait,
  output logic [CPUS*WORD_W-1:0]   iload,
  output logic [CPUS*WORD_W-1:0]   dload,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [WORD_W-1:0]        ramaddr,
  output logic [WORD_W-1:0]        ramstore,
  input  logic [WORD_W-1:0]        ramload,
  input  logic [1:0]               ramstate,
  output logic [OW-1:0]            owner
);

  typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;
  typedef enum logic [1:0] {DREAD = 2'd0, DWRITE = 2'd1, IREAD = 2'd2} kind_t;

  localparam logic [1:0] ACCESS = 2'd2;

  state_t            state;
  state_t            nextstate;
  kind_t             kind;
  kind_t             pickkind;
  logic [OW-1:0]     rr;
  logic [OW-1:0]     pickch;
  logic              pickfound;
  logic [CPUS-1:0]   anyreq;
  logic              live;
  logic              done;
  logic [WORD_W-1:0] ownerdaddr;
  logic [WORD_W-1:0] owneriaddr;
  logic [WORD_W-1:0] ownerdstore;

  assign anyreq = dREN | dWEN | iREN;

  // Read data is broadcast; each cache qualifies it with its own wait bit.
  assign iload = {CPUS{ramload}};
  assign dload = {CPUS{ramload}};

  // Round-robin pick: scan channels rr..CPUS-1 first, then wrap to 0..rr-1.
  always_comb begin
    pickfound = 1'b0;
    pickch    = '0;
    pickkind  = IREAD;
    for (int c = 0; c < CPUS; c++) begin
      if (!pickfound && (c >= int'(rr)) && anyreq[c]) begin
        pickfound = 1'b1;
        pickch    = OW'(c);
        pickkind  = dREN[c] ? DREAD : (dWEN[c] ? DWRITE : IREAD);
      end
    end
    for (int c = 0; c < CPUS; c++) begin
      if (!pickfound && anyreq[c]) begin
        pickfound = 1'b1;
        pickch    = OW'(c);
        pickkind  = dREN[c] ? DREAD : (dWEN[c] ? DWRITE : IREAD);
      end
    end
  end

  // Select the owner's live request bit, addresses and write data.
  always_comb begin
    live        = 1'b0;
    ownerdaddr  = '0;
    owneriaddr  = '0;
    ownerdstore = '0;
    for (int c = 0; c < CPUS; c++) begin
      if (owner == OW'(c)) begin
        ownerdaddr  = daddr[c*WORD_W +: WORD_W];
        owneriaddr  = iaddr[c*WORD_W +: WORD_W];
        ownerdstore = dstore[c*WORD_W +: WORD_W];
        case (kind)
          DREAD:   live = dREN[c];
          DWRITE:  live = dWEN[c];
          default: live = iREN[c];
        endcase
      end
    end
  end

  // A transfer completes only while its request is still held.
  assign done = (state == SERVE) && live && (ramstate == ACCESS);

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= nextstate;
    end
  end

  // Latch the grant on entry to SERVE and advance rr only on completion.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      owner <= '0;
      kind  <= IREAD;
      rr    <= '0;
    end else begin
      if ((state == IDLE) && pickfound) begin
        owner <= pickch;
        kind  <= pickkind;
      end
      if (done) begin
        rr <= (owner == OW'(CPUS - 1)) ? '0 : owner + 1'b1;
      end
    end
  end

  // Next state: leave SERVE on completion or when the owner withdraws.
  always_comb begin
    nextstate = state;
    case (state)
      IDLE:    if (pickfound) nextstate = SERVE;
      SERVE:   if (!live || (ramstate == ACCESS)) nextstate = IDLE;
      default: nextstate = IDLE;
    endcase
  end

  // RAM port and wait bits; everything idles unless the owner still requests.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    if ((state == SERVE) && live) begin
      case (kind)
        DREAD: begin
          ramREN  = 1'b1;
          ramaddr = ownerdaddr;
        end
        DWRITE: begin
          ramWEN   = 1'b1;
          ramaddr  = ownerdaddr;
          ramstore = ownerdstore;
        end
        default: begin
          ramREN  = 1'b1;
          ramaddr = owneriaddr;
        end
      endcase
      if (ramstate == ACCESS) begin
        for (int c = 0; c < CPUS; c++) begin
          if (owner == OW'(c)) begin
            if (kind == IREAD) iwait[c] = 1'b0;
            else               dwait[c] = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scenarios plus randomized batches checked by a
// scoreboard fed from a transaction-level round-robin model.
module tb_ram_arbiter;

  localparam int CPUS = 3;
  localparam int W    = 32;
  localparam int OW   = 2;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic                CLK = 1'b0;
  logic                nRST;
  logic [CPUS-1:0]     iREN, dREN, dWEN, iwait, dwait;
  logic [CPUS*W-1:0]   iaddr, daddr, dstore, iload, dload;
  logic                ramREN, ramWEN;
  logic [W-1:0]        ramaddr, ramstore, ramload;
  logic [1:0]          ramstate;
  logic [OW-1:0]       owner;

  typedef struct {
    int         ch;
    int         kind;
    logic [W-1:0] addr;
    logic [W-1:0] data;
  } exp_t;

  exp_t expq[$];
  int   checks   = 0;
  int   failures = 0;
  bit   sbenable = 1'b0;
  int   mrr      = 0;

  ram_arbiter #(.CPUS(CPUS), .WORD_W(W)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .owner(owner)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    nRST = 1'b0;
    iREN = '0; dREN = '0; dWEN = '0;
    ramstate = FREE;
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
    mrr = 0;
  endtask

  // Issue a random batch, predict completion order with the round-robin model,
  // then play the caches: hold each request until its wait drops.
  task automatic applyStimulus(input int batch);
    bit pend[CPUS][3];
    bit [CPUS-1:0] dropr, dropw, dropi;
    int remaining;
    int cyc;
    for (int c = 0; c < CPUS; c++) begin
      dREN[c] = ($urandom_range(0, 9) < 4);
      dWEN[c] = ($urandom_range(0, 9) < 4);
      iREN[c] = ($urandom_range(0, 9) < 4);
      daddr[c*W +: W]  = $urandom;
      iaddr[c*W +: W]  = $urandom;
      dstore[c*W +: W] = $urandom;
      pend[c][0] = dREN[c];
      pend[c][1] = dWEN[c];
      pend[c][2] = iREN[c];
    end
    remaining = 0;
    for (int c = 0; c < CPUS; c++) remaining += int'(pend[c][0]) + int'(pend[c][1]) + int'(pend[c][2]);
    while (remaining > 0) begin
      for (int k = 0; k < CPUS; k++) begin
        int c;
        c = (mrr + k) % CPUS;
        if (pend[c][0] || pend[c][1] || pend[c][2]) begin
          exp_t e;
          e.kind = pend[c][0] ? 0 : (pend[c][1] ? 1 : 2);
          e.ch   = c;
          e.addr = (e.kind == 2) ? iaddr[c*W +: W] : daddr[c*W +: W];
          e.data = dstore[c*W +: W];
          expq.push_back(e);
          pend[c][e.kind] = 1'b0;
          remaining--;
          mrr = (c + 1) % CPUS;
          break;
        end
      end
    end
    cyc = 0;
    while (((dREN | dWEN | iREN) != '0) && (cyc < 400)) begin
      @(negedge CLK);
      dropr = '0; dropw = '0; dropi = '0;
      for (int c = 0; c < CPUS; c++) begin
        if (!dwait[c]) begin
          if (dREN[c]) dropr[c] = 1'b1;
          else         dropw[c] = 1'b1;
        end
        if (!iwait[c]) dropi[c] = 1'b1;
      end
      tick();
      dREN = dREN & ~dropr;
      dWEN = dWEN & ~dropw;
      iREN = iREN & ~dropi;
      ramstate = ($urandom_range(0, 1) == 1) ? ACCESS : 2'($urandom_range(0, 3));
      ramload  = $urandom;
      cyc++;
    end
    if (cyc >= 400) begin
      checks++;
      failures++;
      $display("[TB] FAIL batch_timeout: batch %0d still pending after %0d cycles", batch, cyc);
      expq.delete();
      doReset();
    end else begin
      checkOutput("sb_drained", 64'(expq.size()), 64'd0);
    end
    repeat (2) tick();
  endtask

  // Scoreboard monitor: every wait pulse must match the next predicted transfer.
  always @(negedge CLK) begin
    int lows;
    int ach;
    int aport;
    exp_t e;
    if (sbenable && nRST) begin
      lows = 0; ach = -1; aport = -1;
      for (int c = 0; c < CPUS; c++) begin
        if (!dwait[c]) begin lows++; ach = c; aport = 0; end
        if (!iwait[c]) begin lows++; ach = c; aport = 1; end
      end
      checkOutput("strobe_exclusive", {63'd0, ramREN & ramWEN}, 64'd0);
      if (lows > 1) begin
        checks++;
        failures++;
        $display("[TB] FAIL one_wait_low: %0d wait bits low at once", lows);
      end else if (lows == 1) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_grant: ch %0d completed, none predicted", ach);
        end else begin
          e = expq.pop_front();
          checkOutput("sb_channel", 64'(ach), 64'(e.ch));
          checkOutput("sb_owner", 64'(owner), 64'(e.ch));
          checkOutput("sb_port", 64'(aport), (e.kind == 2) ? 64'd1 : 64'd0);
          checkOutput("sb_addr", 64'(ramaddr), 64'(e.addr));
          if (e.kind == 1) begin
            checkOutput("sb_strobes_wr", {62'd0, ramREN, ramWEN}, 64'd1);
            checkOutput("sb_store", 64'(ramstore), 64'(e.data));
          end else begin
            checkOutput("sb_strobes_rd", {62'd0, ramREN, ramWEN}, 64'd2);
            checkOutput("sb_load", (e.kind == 2) ? 64'(iload[e.ch*W +: W]) : 64'(dload[e.ch*W +: W]), 64'(ramload));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nRST = 1'b0;
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = 32'h0; ramstate = FREE;
    #1;
    checkOutput("reset_ren", {63'd0, ramREN}, 64'd0);
    checkOutput("reset_wen", {63'd0, ramWEN}, 64'd0);
    checkOutput("reset_addr", 64'(ramaddr), 64'd0);
    checkOutput("reset_store", 64'(ramstore), 64'd0);
    checkOutput("reset_waits", {58'd0, iwait, dwait}, 64'h3F);
    checkOutput("reset_owner", 64'(owner), 64'd0);

    $display("[TB] single data read with delayed ACCESS");
    doReset();
    dREN[0] = 1'b1; daddr[0 +: W] = 32'h40; ramstate = BUSY;
    @(negedge CLK);
    checkOutput("r37_idle_dwait", 64'(dwait), 64'h7);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 2) begin ramstate = ACCESS; ramload = 32'h1234_5678; end
      @(negedge CLK);
      checkOutput("r37_ren", {63'd0, ramREN}, 64'd1);
      checkOutput("r37_addr", 64'(ramaddr), 64'h40);
      checkOutput("r37_dwait", 64'(dwait), (k == 2) ? 64'h6 : 64'h7);
    end
    checkOutput("r37_dload", 64'(dload[0 +: W]), 64'h1234_5678);
    tick();
    dREN = '0; ramstate = FREE;
    @(negedge CLK);
    checkOutput("r37_after", {59'd0, ramREN, dwait}, 64'h7);

    $display("[TB] two channels alternating instruction reads");
    doReset();
    iREN = 3'b011; iaddr[0 +: W] = 32'h1000; iaddr[W +: W] = 32'h2000; ramstate = ACCESS;
    for (int g = 0; g < 4; g++) begin
      @(negedge CLK);
      checkOutput("r38_idle_iwait", 64'(iwait), 64'h7);
      tick();
      @(negedge CLK);
      checkOutput("r38_owner", 64'(owner), 64'(g % 2));
      checkOutput("r38_iwait", 64'(iwait), 64'(3'b111 ^ (3'b001 << (g % 2))));
      checkOutput("r38_addr", 64'(ramaddr), (g % 2 == 0) ? 64'h1000 : 64'h2000);
      tick();
    end
    iREN = '0;

    $display("[TB] write takes priority over instruction read");
    doReset();
    dWEN[1] = 1'b1; daddr[W +: W] = 32'h80; dstore[W +: W] = 32'hDEAD_BEEF;
    iREN[1] = 1'b1; iaddr[W +: W] = 32'h100; ramstate = ACCESS;
    @(negedge CLK);
    tick();
    @(negedge CLK);
    checkOutput("r39_strobes_wr", {62'd0, ramREN, ramWEN}, 64'd1);
    checkOutput("r39_addr_wr", 64'(ramaddr), 64'h80);
    checkOutput("r39_store", 64'(ramstore), 64'hDEAD_BEEF);
    checkOutput("r39_waits_wr", {58'd0, iwait, dwait}, 64'h3D);
    tick();
    dWEN = '0;
    @(negedge CLK);
    tick();
    @(negedge CLK);
    checkOutput("r39_strobes_rd", {62'd0, ramREN, ramWEN}, 64'd2);
    checkOutput("r39_addr_rd", 64'(ramaddr), 64'h100);
    checkOutput("r39_waits_rd", {58'd0, iwait, dwait}, 64'h2F);
    tick();
    iREN = '0;

    $display("[TB] ERROR retried until ACCESS");
    doReset();
    dREN[0] = 1'b1; daddr[0 +: W] = 32'h44; ramstate = ERROR;
    @(negedge CLK);
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge CLK);
      checkOutput("r40_err_dwait", 64'(dwait), 64'h7);
      checkOutput("r40_err_ren", {63'd0, ramREN}, 64'd1);
    end
    tick();
    ramstate = ACCESS;
    @(negedge CLK);
    checkOutput("r40_done_dwait", 64'(dwait), 64'h6);
    tick();
    dREN = '0;
    @(negedge CLK);
    checkOutput("r40_after_dwait", 64'(dwait), 64'h7);

    $display("[TB] owner withdraws mid-transfer");
    doReset();
    dREN[0] = 1'b1; daddr[0 +: W] = 32'h48; ramstate = BUSY;
    @(negedge CLK);
    tick();
    @(negedge CLK);
    checkOutput("r41_owner", 64'(owner), 64'd0);
    tick();
    dREN = '0;
    @(negedge CLK);
    checkOutput("r41_drop", {59'd0, ramREN, dwait}, 64'h7);
    tick();
    iREN = 3'b011; iaddr[0 +: W] = 32'h500; iaddr[W +: W] = 32'h600; ramstate = ACCESS;
    @(negedge CLK);
    checkOutput("r41_idle", {59'd0, ramREN, iwait}, 64'h7);
    tick();
    @(negedge CLK);
    checkOutput("r41_regrant_owner", 64'(owner), 64'd0);
    checkOutput("r41_regrant_iwait", 64'(iwait), 64'h6);
    tick();
    iREN = '0;

    $display("[TB] reset during SERVE");
    doReset();
    dREN[0] = 1'b1; daddr[0 +: W] = 32'h50; ramstate = ACCESS;
    @(negedge CLK);
    tick();
    @(negedge CLK);
    checkOutput("r42_first_dwait", 64'(dwait), 64'h6);
    tick();
    dREN = 3'b010; daddr[W +: W] = 32'h60;
    iREN = 3'b001; iaddr[0 +: W] = 32'h3000; ramstate = BUSY;
    @(negedge CLK);
    tick();
    @(negedge CLK);
    checkOutput("r42_serve_owner", 64'(owner), 64'd1);
    checkOutput("r42_serve_addr", 64'(ramaddr), 64'h60);
    #2;
    nRST = 1'b0;
    #1;
    checkOutput("r42_rst_strobes", {62'd0, ramREN, ramWEN}, 64'd0);
    checkOutput("r42_rst_addr", 64'(ramaddr), 64'd0);
    checkOutput("r42_rst_waits", {58'd0, iwait, dwait}, 64'h3F);
    checkOutput("r42_rst_owner", 64'(owner), 64'd0);
    tick();
    nRST = 1'b1;
    @(negedge CLK);
    tick();
    @(negedge CLK);
    checkOutput("r42_post_owner", 64'(owner), 64'd0);
    checkOutput("r42_post_addr", 64'(ramaddr), 64'h3000);

    $display("[TB] randomized batches");
    doReset();
    sbenable = 1'b1;
    for (int b = 0; b < 40; b++) applyStimulus(b);
    sbenable = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
